// File: rtl/decode_scan.sv
// rtl/decode_scan.sv - registered one-hot decoder with auto-scan mode
module decode_scan #(
    parameter int N       = 2,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [N-1:0]         in,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [(1<<N)-1:0]    out,
    output logic [N-1:0]         idx,
    output logic                 wrap
);
    localparam int W = 1 << N;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       out_q, out_d;
    logic [N-1:0]       idx_q, idx_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        out_d  = '0;
        idx_d  = '0;
        wrap_d = 1'b0;
        cnt_d  = '0;
        if (!en)
            state_d = ST_IDLE;
        else if (mode)
            state_d = ST_SCAN;
        else
            state_d = ST_DECODE;

        case (state_d)
            ST_DECODE: begin
                // Compare per line so an unknown select matches nothing and out stays zero.
                for (int i = 0; i < W; i++) begin
                    if (in == N'(i)) begin
                        out_d[i] = 1'b1;
                        idx_d    = N'(i);
                    end
                end
            end
            ST_SCAN: begin
                if (state_q != ST_SCAN) begin
                    out_d[0] = 1'b1;
                end else if (cnt_q >= dwell) begin
                    idx_d        = idx_q + N'(1);
                    wrap_d       = (idx_q == {N{1'b1}});
                    out_d[idx_d] = 1'b1;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                    idx_d = idx_q;
                    out_d = out_q;
                end
            end
            default: ;
        endcase
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;
endmodule

// File: doc/decode_scan.md
DECODE_SCAN -- requirements
Module: decode_scan

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning select width; the output width is 2**N; legal range is 1..6.
REQ-002 The block SHALL have parameter DWELL_W, default 8, meaning the width of the scan dwell count.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named as listed in REQ-004 and REQ-005.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  block enable; 0 forces all outputs to zero.
REQ-007 mode  input  1  operating mode; 0 selects registered decode, 1 selects auto-scan.
REQ-008 in  input  N  decode select, used in decode mode only.
REQ-009 dwell  input  DWELL_W  scan step interval; the output line advances every dwell+1 cycles.
REQ-010 out  output  2**N  registered one-hot output line, or all-zero.
REQ-011 idx  output  N  binary index of the active line; 0 when out is zero.
REQ-012 wrap  output  1  one-cycle pulse on the cycle scan idx changes from 2**N-1 to 0.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, DECODE and SCAN, sampled on the rising edge of clk.
REQ-014 The block SHALL take the next state from en and mode each cycle: en=0 -> IDLE; en=1,mode=0 -> DECODE; en=1,mode=1 -> SCAN.
REQ-015 In IDLE the block SHALL drive out=0, idx=0 and wrap=0, and SHALL hold the dwell counter at 0.
REQ-016 In DECODE the block SHALL drive out = 1<<in and idx = in, with one cycle of latency from the in sample.
REQ-017 In DECODE the block SHALL hold wrap at 0 and the dwell counter at 0.
REQ-018 On entry to SCAN from any other state, the block SHALL set idx=0, out=1 and counter=0 in the first SCAN cycle.
REQ-019 In SCAN, the block SHALL increment the counter each cycle while counter < dwell.
REQ-020 In SCAN, when counter >= dwell, the block SHALL clear the counter and advance idx by 1 modulo 2**N on the next edge, with out = 1<<idx.
REQ-021 dwell=0 SHALL advance idx every cycle.
REQ-022 dwell SHALL be sampled live; if it is lowered below the current counter value, the advance SHALL occur on the next edge.
REQ-023 wrap SHALL be asserted for exactly the one cycle in which idx=0 follows idx=2**N-1 within continuous SCAN; entry into SCAN SHALL NOT pulse wrap.
REQ-024 A mode change DECODE->SCAN or SCAN->DECODE SHALL take effect on the next edge; scan position SHALL NOT be retained across leaving SCAN.
REQ-025 en falling mid-scan SHALL produce out=0 and idx=0 on the next edge.
REQ-026 out SHALL always be either zero or exactly one-hot; no X or multi-hot value SHALL ever appear, including for in values that contain X.
REQ-027 All outputs SHALL be registered; there SHALL be no combinational path from the inputs to the outputs.

Reset
REQ-028 On rst_n=0, the block SHALL immediately, without waiting for a clock edge, set state=IDLE, out=0, idx=0, wrap=0 and counter=0.
REQ-029 The block SHALL leave reset on the first rising clk edge with rst_n=1, evaluating en and mode as in REQ-014.
REQ-030 An assertion of rst_n mid-scan SHALL abort the scan; after release, SCAN SHALL restart at idx=0.

Verification (N=2, DWELL_W=8)
REQ-031 The bench SHALL drive en=1, mode=0, in=2'b10 and check that out=4'b0100, idx=2 one edge later; with en=0, out=4'b0000.
REQ-032 The bench SHALL drive en=1, mode=1, dwell=0 and check that out steps 0001,0010,0100,1000,0001 on successive edges, with wrap=1 only on the 1000->0001 cycle.
REQ-033 The bench SHALL drive mode=1 with dwell=3 and check that each line is held for 4 cycles, and that the wrap period is 16 cycles.
REQ-034 The bench SHALL lower dwell from 200 to 5 while the counter is at 50 and check that idx advances on the next edge.
REQ-035 The bench SHALL assert rst_n=0 mid-cycle while out=0100 and check that out=0 before the next edge; after release with mode=1, out=0001 and wrap stays 0.
REQ-036 The bench SHALL switch SCAN->DECODE->SCAN with in=3 and check that out goes 1000 (DECODE) then restarts at 0001.
